// File: rtl/tdm_demux_sequencer.sv
// tdm_demux_sequencer: serial-to-TDM front end for the 1-to-8 demux stage.
// Accepted bits are assigned round-robin to the enabled channels of a mask
// latched at start; each bit is held on sel/dmx_in for hold+1 cycles.
module tdm_demux_sequencer #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        ch_mask,
  input  logic [HOLD_W-1:0] hold,
  input  logic              din_valid,
  input  logic              din,
  output logic              din_ready,
  output logic [2:0]        sel,
  output logic              dmx_in,
  output logic              slot_valid,
  output logic              frame_start,
  output logic              busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [7:0]        mask;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stop_pending;

  logic [2:0]        nxt;
  logic [2:0]        lowest;
  logic              nxt_found;
  logic              low_found;
  logic              accept;

  // Ready only in RUN, with no stop seen, and when no slot is being held.
  assign din_ready = (state == RUN) && !stop && !stop_pending &&
                     (!slot_valid || hold_cnt == '0);
  assign accept    = din_valid && din_ready;

  // Circular search for the next enabled channel after ptr, plus the lowest enabled channel.
  always_comb begin
    nxt       = ptr;
    nxt_found = 1'b0;
    lowest    = '0;
    low_found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!nxt_found && mask[ptr + 3'(i)]) begin
        nxt       = ptr + 3'(i);
        nxt_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (!low_found && mask[i]) begin
        lowest    = 3'(i);
        low_found = 1'b1;
      end
    end
  end

  // Run/idle sequencing with registered demux outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask         <= '0;
      ptr          <= 3'd7;
      hold_cnt     <= '0;
      stop_pending <= 1'b0;
      sel          <= '0;
      dmx_in       <= 1'b0;
      slot_valid   <= 1'b0;
      frame_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop && ch_mask != '0) begin
            mask         <= ch_mask;
            ptr          <= 3'd7;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sel         <= nxt;
            dmx_in      <= din;
            slot_valid  <= 1'b1;
            hold_cnt    <= hold;
            ptr         <= nxt;
            frame_start <= (nxt == lowest);
          end else if (slot_valid && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (stop) stop_pending <= 1'b1;
          end else begin
            // No slot live past this edge; a pending stop can retire here.
            slot_valid  <= 1'b0;
            dmx_in      <= 1'b0;
            frame_start <= 1'b0;
            if (stop || stop_pending) begin
              state        <= IDLE;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_sequencer.sv
// Scoreboard bench for tdm_demux_sequencer: the driver pushes the expected
// slot for every accepted bit; a monitor pops and checks each presented slot.
module tb_tdm_demux_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [3:0] hold = '0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       din_ready;
  logic [2:0] sel;
  logic       dmx_in;
  logic       slot_valid;
  logic       frame_start;
  logic       busy;

  tdm_demux_sequencer #(.HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_mask(ch_mask),
    .hold(hold), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .sel(sel), .dmx_in(dmx_in), .slot_valid(slot_valid),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic       d;
    logic       f;
    logic [3:0] h;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         ready_chk = 1'b0;
  int         rem = 0;
  logic [2:0] cur_sel = '0;
  logic       cur_d = 1'b0;
  logic       cur_f = 1'b0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one look per cycle, just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (slot_valid) begin
          if (rem == 0) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_slot actual sel=%0d required no slot", sel);
            end else begin
              e = q.pop_front();
              chk("slot_sel", {5'b0, sel}, {5'b0, e.s});
              chk("slot_dmx_in", {7'b0, dmx_in}, {7'b0, e.d});
              chk("slot_frame_start", {7'b0, frame_start}, {7'b0, e.f});
              rem = int'(e.h);
              cur_sel = e.s;
              cur_d = e.d;
              cur_f = e.f;
            end
          end else begin
            rem--;
            chk("held_sel", {5'b0, sel}, {5'b0, cur_sel});
            chk("held_dmx_in", {7'b0, dmx_in}, {7'b0, cur_d});
            chk("held_frame_start", {7'b0, frame_start}, {7'b0, cur_f});
          end
        end else begin
          chk("slot_length_left", 8'(rem), 8'd0);
          rem = 0;
          chk("gap_dmx_in", {7'b0, dmx_in}, 8'd0);
          chk("gap_frame_start", {7'b0, frame_start}, 8'd0);
          chk("gap_sel_hold", {5'b0, sel}, {5'b0, cur_sel});
        end
        if (ready_chk && busy)
          chk("din_ready", {7'b0, din_ready}, {7'b0, (!slot_valid || rem == 0)});
      end
    end
  end

  // All driver tasks start and end at a falling edge.
  task automatic do_start(input logic [7:0] m, input logic s);
    start = 1'b1;
    stop = s;
    ch_mask = m;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    ch_mask = ~m;
  endtask

  task automatic send(input logic b, input logic [2:0] es, input logic ef,
                      input logic [3:0] h, input int ew);
    int t = 0;
    bit acc = 1'b0;
    din_valid = 1'b1;
    din = b;
    hold = h;
    while (!acc && t < 40) begin
      #1;
      if (din_ready) begin
        q.push_back('{s: es, d: b, f: ef, h: h});
        acc = 1'b1;
      end else begin
        t++;
      end
      @(negedge clk);
    end
    chk("accepted", {7'b0, acc}, 8'd1);
    if (acc && ew >= 0) chk("accept_wait", 8'(t), 8'(ew));
  endtask

  task automatic do_stop();
    int t = 0;
    ready_chk = 1'b0;
    din_valid = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("stop_to_idle", {7'b0, busy}, 8'd0);
    ready_chk = 1'b1;
  endtask

  initial begin
    logic [8:0] bits2;
    bits2 = 9'b1_0010_1101; // LSB first: 1,0,1,1,0,1,0,0,1

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sel", {5'b0, sel}, 8'd0);
    chk("rst_dmx_in", {7'b0, dmx_in}, 8'd0);
    chk("rst_slot_valid", {7'b0, slot_valid}, 8'd0);
    chk("rst_frame_start", {7'b0, frame_start}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_din_ready", {7'b0, din_ready}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-slot with hold_cnt=5
    do_start(8'hFF, 1'b0);
    chk("start_busy", {7'b0, busy}, 8'd1);
    din_valid = 1'b1;
    din = 1'b1;
    hold = 4'd5;
    @(negedge clk);
    din_valid = 1'b0;
    chk("pre_rst_slot_valid", {7'b0, slot_valid}, 8'd1);
    chk("pre_rst_dmx_in", {7'b0, dmx_in}, 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sel", {5'b0, sel}, 8'd0);
    chk("midrst_dmx_in", {7'b0, dmx_in}, 8'd0);
    chk("midrst_slot_valid", {7'b0, slot_valid}, 8'd0);
    chk("midrst_frame_start", {7'b0, frame_start}, 8'd0);
    chk("midrst_busy", {7'b0, busy}, 8'd0);
    chk("midrst_din_ready", {7'b0, din_ready}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cur_sel = '0;
    rem = 0;
    mon_en = 1'b1;
    ready_chk = 1'b1;

    // All channels, hold 0, continuous valid: sel 0..7,0 back-to-back
    do_start(8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      logic [2:0] s;
      s = 3'(i);
      send(bits2[i], s, (s == 3'd0), 4'd0, 0);
    end
    do_stop();

    // Sparse mask 1010_0100, hold 2: sel 2,5,7,2, three cycles each
    do_start(8'b1010_0100, 1'b0);
    send(1'b1, 3'd2, 1'b1, 4'd2, 0);
    send(1'b1, 3'd5, 1'b0, 4'd2, 2);
    send(1'b0, 3'd7, 1'b0, 4'd2, 2);
    send(1'b1, 3'd2, 1'b1, 4'd2, 2);
    do_stop();

    // Single channel 4: repeats, frame_start every slot
    do_start(8'h10, 1'b0);
    send(1'b1, 3'd4, 1'b1, 4'd0, 0);
    send(1'b0, 3'd4, 1'b1, 4'd0, 0);
    send(1'b1, 3'd4, 1'b1, 4'd0, 0);
    do_stop();

    // Start with empty mask is ignored
    do_start(8'h00, 1'b0);
    @(negedge clk);
    chk("mask0_busy", {7'b0, busy}, 8'd0);
    chk("mask0_din_ready", {7'b0, din_ready}, 8'd0);

    // Stop with no slot active: ready drops combinationally, idle next edge
    do_start(8'hFF, 1'b0);
    hold = 4'd0;
    #1;
    chk("run_ready", {7'b0, din_ready}, 8'd1);
    ready_chk = 1'b0;
    din_valid = 1'b1;
    stop = 1'b1;
    #1;
    chk("stop_ready_comb", {7'b0, din_ready}, 8'd0);
    @(negedge clk);
    stop = 1'b0;
    din_valid = 1'b0;
    chk("stop_noslot_busy", {7'b0, busy}, 8'd0);
    chk("stop_noslot_slot_valid", {7'b0, slot_valid}, 8'd0);
    ready_chk = 1'b1;

    // Stop on 2nd cycle of a 4-cycle slot: slot completes, then idle
    do_start(8'hFF, 1'b0);
    send(1'b1, 3'd0, 1'b1, 4'd3, 0);
    din = 1'b0;
    @(negedge clk);
    ready_chk = 1'b0;
    stop = 1'b1;
    #1;
    chk("midstop_ready", {7'b0, din_ready}, 8'd0);
    @(negedge clk);
    stop = 1'b0;
    chk("midstop_c3_ready", {7'b0, din_ready}, 8'd0);
    chk("midstop_c3_slot_valid", {7'b0, slot_valid}, 8'd1);
    @(negedge clk);
    chk("midstop_c4_ready", {7'b0, din_ready}, 8'd0);
    chk("midstop_c4_slot_valid", {7'b0, slot_valid}, 8'd1);
    chk("midstop_c4_busy", {7'b0, busy}, 8'd1);
    @(negedge clk);
    din_valid = 1'b0;
    chk("midstop_end_busy", {7'b0, busy}, 8'd0);
    chk("midstop_end_slot_valid", {7'b0, slot_valid}, 8'd0);
    chk("midstop_end_dmx_in", {7'b0, dmx_in}, 8'd0);
    ready_chk = 1'b1;

    // Valid gap after sel=3: sel holds, order resumes at 4
    do_start(8'hFF, 1'b0);
    send(1'b1, 3'd0, 1'b1, 4'd0, 0);
    send(1'b0, 3'd1, 1'b0, 4'd0, 0);
    send(1'b1, 3'd2, 1'b0, 4'd0, 0);
    send(1'b1, 3'd3, 1'b0, 4'd0, 0);
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gapt_slot_valid", {7'b0, slot_valid}, 8'd0);
      chk("gapt_sel", {5'b0, sel}, 8'd3);
      chk("gapt_dmx_in", {7'b0, dmx_in}, 8'd0);
    end
    send(1'b1, 3'd4, 1'b0, 4'd0, 0);
    do_stop();

    // start and stop together in IDLE: stop wins
    do_start(8'hFF, 1'b1);
    chk("startstop_busy", {7'b0, busy}, 8'd0);
    chk("startstop_din_ready", {7'b0, din_ready}, 8'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
